// File: rtl/alu_rx_frontend.sv
// -----------------------------------------------------------------------------
// alu_rx_frontend
//
// Purpose:
//   Sits between a UART receiver/transmitter pair and a combinational ALU.
//   Collects a three-byte frame (operand A, operand B, opcode) from the
//   receive byte stream and presents it to the ALU as registered operands.
//   One cycle later it captures the ALU result, sign-extends it to the UART
//   byte width and issues a one-cycle transmit request. It then waits for the
//   transmitter to finish before accepting the next frame.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_rx_data      received byte, valid while i_rx_done is high
//   i_rx_done      one-cycle pulse: a byte is available
//   i_tx_done      one-cycle pulse: transmitter finished the byte
//   i_resultado    ALU result, combinational from o_dato_a/o_dato_b/o_operador
//   o_dato_a       registered operand A
//   o_dato_b       registered operand B
//   o_operador     registered opcode
//   o_tx_data      sign-extended result for the transmitter
//   o_tx_start     one-cycle transmit request
//   o_frame_error  one-cycle pulse when an idle timeout drops a partial frame
//   o_rx_overrun   sticky: a byte arrived while a result was being sent
// -----------------------------------------------------------------------------
module alu_rx_frontend #(
  parameter int NB_DATA        = 8,
  parameter int NB_OPERADOR    = 6,
  parameter int NB_UART        = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NB_UART-1:0]     i_rx_data,
  input  logic                   i_rx_done,
  input  logic                   i_tx_done,
  input  logic [NB_DATA-1:0]     i_resultado,
  output logic [NB_DATA-1:0]     o_dato_a,
  output logic [NB_DATA-1:0]     o_dato_b,
  output logic [NB_OPERADOR-1:0] o_operador,
  output logic [NB_UART-1:0]     o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_frame_error,
  output logic                   o_rx_overrun
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [NB_DATA-1:0]      dato_a_q, dato_a_d;
  logic [NB_DATA-1:0]      dato_b_q, dato_b_d;
  logic [NB_OPERADOR-1:0]  operador_q, operador_d;
  logic [NB_UART-1:0]      tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    frame_error_q, frame_error_d;
  logic                    rx_overrun_q, rx_overrun_d;

  logic                    in_frame;
  logic                    busy;
  logic                    timeout_fire;
  logic [NB_UART-1:0]      resultado_ext;

  // Upper bits of received bytes beyond the operand/opcode widths are
  // intentionally dropped; fold them here so they are visibly consumed.
  logic                    unused_rx_bits;
  assign unused_rx_bits = ^i_rx_data;

  // Mid-frame states are the only ones subject to the idle timeout.
  assign in_frame = (state_q == WAIT_B) || (state_q == WAIT_OP);
  // While a result is in flight any received byte is an overrun.
  assign busy     = (state_q == SEND) || (state_q == WAIT_TX);

  // ---------------------------------------------------------------------------
  // Idle timeout. The counter holds the number of idle cycles already spent
  // mid-frame, so it fires during the TIMEOUT_CYCLES-th idle cycle and the
  // state returns to WAIT_A at the end of that cycle. A byte arriving in that
  // same cycle wins because the fire condition requires !i_rx_done.
  // ---------------------------------------------------------------------------
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign timeout_fire = in_frame && !i_rx_done && (cnt_q == CNT_LAST);

      always_comb begin
        cnt_d = '0;
        if (in_frame && !i_rx_done && !timeout_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_timeout
      assign timeout_fire = 1'b0;
    end
  endgenerate

  // Sign-extend the ALU result to the UART byte width.
  generate
    if (NB_UART > NB_DATA) begin : g_sext
      assign resultado_ext = {{(NB_UART-NB_DATA){i_resultado[NB_DATA-1]}}, i_resultado};
    end else begin : g_no_sext
      assign resultado_ext = i_resultado;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A: begin
        if (i_rx_done) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (i_rx_done)         state_d = WAIT_OP;
        else if (timeout_fire) state_d = WAIT_A;
      end
      WAIT_OP: begin
        if (i_rx_done)         state_d = SEND;
        else if (timeout_fire) state_d = WAIT_A;
      end
      SEND: begin
        // Operands have been stable for a full cycle, so the ALU result is
        // captured on the edge leaving this state.
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    dato_a_d      = dato_a_q;
    dato_b_d      = dato_b_q;
    operador_d    = operador_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    frame_error_d = timeout_fire;
    rx_overrun_d  = rx_overrun_q | (i_rx_done & busy);

    case (state_q)
      WAIT_A: begin
        if (i_rx_done) dato_a_d = i_rx_data[NB_DATA-1:0];
      end
      WAIT_B: begin
        if (i_rx_done) dato_b_d = i_rx_data[NB_DATA-1:0];
      end
      WAIT_OP: begin
        if (i_rx_done) operador_d = i_rx_data[NB_OPERADOR-1:0];
      end
      SEND: begin
        tx_data_d  = resultado_ext;
        tx_start_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dato_a_q      <= '0;
      dato_b_q      <= '0;
      operador_q    <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      frame_error_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      dato_a_q      <= dato_a_d;
      dato_b_q      <= dato_b_d;
      operador_q    <= operador_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      frame_error_q <= frame_error_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  assign o_dato_a      = dato_a_q;
  assign o_dato_b      = dato_b_q;
  assign o_operador    = operador_q;
  assign o_tx_data     = tx_data_q;
  assign o_tx_start    = tx_start_q;
  assign o_frame_error = frame_error_q;
  assign o_rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_alu_rx_frontend.sv
// -----------------------------------------------------------------------------
// tb_alu_rx_frontend
//
// Drives two instances from one byte stream: an 8-bit datapath and a 5-bit
// datapath, both with a 16-cycle idle timeout. Each instance has its own
// behavioural ALU hooked to its operand outputs. Expected values come from a
// frame-level model (last accepted bytes, busy flag, sticky overrun) and an
// integer-arithmetic ALU reference evaluated on the bytes the bench sent.
// -----------------------------------------------------------------------------
module tb_alu_rx_frontend;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;

  logic [7:0] a8, b8, tx8, res8;
  logic [5:0] op8;
  logic       start8, ferr8, ovr8;

  logic [4:0] a5, b5, res5;
  logic [5:0] op5;
  logic [7:0] tx5, res5_full;
  logic       start5, ferr5, ovr5;

  int checks   = 0;
  int failures = 0;

  // frame-level model
  logic [7:0] m_a, m_b, m_op, m_tx8, m_tx5;
  logic       m_ovr;
  int         m_idx;   // 0,1,2 = next byte is A,B,OP ; 3 = result in flight

  always #5 clk = ~clk;

  alu_rx_frontend #(
    .NB_DATA(8), .NB_OPERADOR(6), .NB_UART(8), .TIMEOUT_CYCLES(16)
  ) dut8 (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_resultado(res8), .o_dato_a(a8), .o_dato_b(b8),
    .o_operador(op8), .o_tx_data(tx8), .o_tx_start(start8),
    .o_frame_error(ferr8), .o_rx_overrun(ovr8)
  );

  alu_rx_frontend #(
    .NB_DATA(5), .NB_OPERADOR(6), .NB_UART(8), .TIMEOUT_CYCLES(16)
  ) dut5 (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_resultado(res5), .o_dato_a(a5), .o_dato_b(b5),
    .o_operador(op5), .o_tx_data(tx5), .o_tx_start(start5),
    .o_frame_error(ferr5), .o_rx_overrun(ovr5)
  );

  // Reference ALU of width w; result returned sign-extended to 8 bits.
  function automatic logic [7:0] alu_ref(input int w, input logic [7:0] a,
                                         input logic [7:0] b, input logic [5:0] op);
    int mask, ua, ub, sa, sb, r;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    sa = (ua >= (1 << (w-1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w-1))) ? ub - (1 << w) : ub;
    case (op)
      6'h20: r = sa + sb;
      6'h22: r = sa - sb;
      6'h24: r = ua & ub;
      6'h25: r = ua | ub;
      6'h26: r = ua ^ ub;
      6'h27: r = ~(ua | ub);
      6'h03: r = sa >>> ub;
      6'h02: r = ua >> ub;
      default: r = 0;
    endcase
    r = r & mask;
    if (r >= (1 << (w-1))) r = r | ~mask;
    return r[7:0];
  endfunction

  always_comb res8 = alu_ref(8, a8, b8, op8);
  always_comb begin
    res5_full = alu_ref(5, {3'b000, a5}, {3'b000, b5}, op5);
    res5      = res5_full[4:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_tx8 = 0; m_tx5 = 0; m_ovr = 0; m_idx = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".a8"},   32'(a8),   32'(m_a));
    chk({tag, ".b8"},   32'(b8),   32'(m_b));
    chk({tag, ".op8"},  32'(op8),  32'(m_op[5:0]));
    chk({tag, ".a5"},   32'(a5),   32'(m_a[4:0]));
    chk({tag, ".b5"},   32'(b5),   32'(m_b[4:0]));
    chk({tag, ".op5"},  32'(op5),  32'(m_op[5:0]));
    chk({tag, ".tx8"},  32'(tx8),  32'(m_tx8));
    chk({tag, ".tx5"},  32'(tx5),  32'(m_tx5));
    chk({tag, ".ovr8"}, 32'(ovr8), 32'(m_ovr));
    chk({tag, ".ovr5"}, 32'(ovr5), 32'(m_ovr));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".zero8"}, 32'({a8, b8, op8, tx8, start8, ferr8, ovr8}), 32'd0);
    chk({tag, ".zero5"}, 32'({a5, b5, op5, tx5, start5, ferr5, ovr5}), 32'd0);
  endtask

  // Present one byte for one cycle and update the model for it.
  task automatic send_byte(input logic [7:0] v);
    rx_data = v;
    rx_done = 1'b1;
    case (m_idx)
      0: begin m_a = v; m_idx = 1; end
      1: begin m_b = v; m_idx = 2; end
      2: begin
        m_op  = v; m_idx = 3;
        m_tx8 = alu_ref(8, m_a, m_b, {2'b00, v[5:0]});
        m_tx5 = alu_ref(5, m_a, m_b, {2'b00, v[5:0]});
      end
      default: m_ovr = 1'b1;
    endcase
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".ferr"}, 32'({ferr8, ferr5}), 32'd0);
    end
  endtask

  // mode 0: plain frame; 1: a byte collides with i_tx_done;
  // 2: a byte arrives during WAIT_TX before i_tx_done.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap_ab, input int gap_bo, input int txdly,
                           input int mode, input string tag);
    send_byte(a);
    idle(gap_ab, tag);
    send_byte(b);
    idle(gap_bo, tag);
    send_byte(op);
    // SEND cycle: no request yet
    chk({tag, ".start_send"}, 32'({start8, start5}), 32'd0);
    @(negedge clk);
    // first WAIT_TX cycle: request and captured result
    chk({tag, ".start"}, 32'({start8, start5}), 32'b11);
    chk_state(tag);
    $display("frame %s a=%02h b=%02h op=%02h tx8=%02h tx5=%02h", tag, a, b, op, tx8, tx5);
    if (mode == 2) begin
      send_byte(8'($urandom));
      chk_state({tag, ".midovr"});
    end
    if (txdly > 0) begin
      @(negedge clk);
      chk({tag, ".start_1cyc"}, 32'({start8, start5}), 32'd0);
      for (int i = 1; i < txdly; i++) @(negedge clk);
    end
    tx_done = 1'b1;
    if (mode == 1) begin
      rx_data = 8'($urandom);
      rx_done = 1'b1;
      m_ovr   = 1'b1;
    end
    m_idx = 0;
    @(negedge clk);
    tx_done = 1'b0;
    rx_done = 1'b0;
    chk({tag, ".start_after"}, 32'({start8, start5}), 32'd0);
    chk_state({tag, ".after"});
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_zero(tag);
  endtask

  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // directed vectors
    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 2, 0, "add");
    chk("add.tx8_const", 32'(tx8), 32'h08);
    run_frame(8'h03, 8'h05, 8'h22, 1, 2, 0, 0, "sub");
    chk("sub.tx8_const", 32'(tx8), 32'hFE);
    run_frame(8'h80, 8'h02, 8'h03, 0, 3, 1, 0, "sra");
    chk("sra.tx8_const", 32'(tx8), 32'hE0);
    run_frame(8'hF0, 8'h01, 8'hC3, 2, 0, 1, 0, "nb5");
    chk("nb5.a5_const",  32'(a5),  32'h10);
    chk("nb5.op5_const", 32'(op5), 32'h03);
    chk("nb5.tx5_const", 32'(tx5), 32'hF8);

    // byte coinciding with i_tx_done is an overrun; next A accepted right after
    run_frame(8'h07, 8'h01, 8'h20, 0, 0, 1, 1, "collide");
    chk("collide.ovr_const", 32'({ovr8, ovr5}), 32'b11);
    run_frame(8'h09, 8'h04, 8'h22, 0, 0, 0, 0, "b2b");

    do_reset("rst1");

    // timeout after A: error pulse at the end of the 16th idle cycle
    send_byte(8'h11);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("tmo.ferr%0d", k), 32'({ferr8, ferr5}), (k == 16) ? 32'b11 : 32'b00);
    end
    m_idx = 0;
    chk_state("tmo.partial");
    run_frame(8'h01, 8'h02, 8'h25, 0, 0, 0, 0, "tmo_or");
    chk("tmo_or.tx8_const", 32'(tx8), 32'h03);

    // bytes arriving on the 16th idle cycle are accepted, no error
    run_frame(8'h21, 8'h13, 8'h26, 15, 15, 1, 0, "edge16");
    idle(3, "edge16.post");

    // byte during WAIT_TX sets overrun and leaves the frame intact
    run_frame(8'h0C, 8'h0A, 8'h24, 0, 0, 2, 2, "midovr");
    chk("midovr.ovr_const", 32'({ovr8, ovr5}), 32'b11);

    // reset after B aborts the frame; next three bytes form a fresh frame
    send_byte(8'h55);
    send_byte(8'h66);
    do_reset("rst_mid");
    run_frame(8'h0F, 8'h01, 8'h20, 0, 0, 0, 0, "fresh");

    // randomized frames
    for (int n = 0; n < 30; n++) begin
      run_frame(8'($urandom), 8'($urandom_range(0, 9)), {2'($urandom), ops[$urandom_range(0, 7)]},
                $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 4),
                $urandom_range(0, 5) == 0 ? 2 : 0, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rx_frontend.md
Name: alu_rx_frontend

Overview:
- Operand/opcode source for the ALU: assembles the three-byte frame A, B, OP from a UART receiver byte stream and drives the registered operands into the ALU.
- Captures the ALU's combinational result and hands it to a UART transmitter with a start/done handshake.
- Sits between uart_rx/uart_tx and the ALU, clocked on the system clock.

Parameters:
- NB_DATA, 8, ALU operand/result width; must satisfy 1 <= NB_DATA <= NB_UART.
- NB_OPERADOR, 6, ALU opcode width; must satisfy NB_OPERADOR <= NB_UART.
- NB_UART, 8, UART byte width.
- TIMEOUT_CYCLES, 1000, idle cycles allowed mid-frame before resync; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_UART  received byte; valid only when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse, byte available.
- i_tx_done  in  1  one-cycle pulse, transmitter finished the byte.
- i_resultado  in  NB_DATA  ALU result (combinational from o_dato_a/o_dato_b/o_operador).
- o_dato_a  out  NB_DATA  registered operand A.
- o_dato_b  out  NB_DATA  registered operand B.
- o_operador  out  NB_OPERADOR  registered opcode.
- o_tx_data  out  NB_UART  result, sign-extended to NB_UART.
- o_tx_start  out  1  one-cycle transmit request.
- o_frame_error  out  1  one-cycle pulse on timeout resync.
- o_rx_overrun  out  1  sticky; a byte arrived while the result was being sent.

Behaviour:
- Reset (sync, active-high):
  - Every output is 0; state is WAIT_A; timeout counter is 0.
  - Reset wins over every other event and aborts any frame or transmission in progress.
- States: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_dato_a <= i_rx_data[NB_DATA-1:0]; go to WAIT_B.
- WAIT_B: on i_rx_done, o_dato_b <= i_rx_data[NB_DATA-1:0]; go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_operador <= i_rx_data[NB_OPERADOR-1:0]; go to SEND.
- Unused upper bits of received bytes are discarded.
- SEND (exactly one cycle; ALU inputs are stable):
  - At the next edge, o_tx_data <= sign-extended i_resultado and o_tx_start <= 1.
  - Go to WAIT_TX.
- o_tx_start timing:
  - High for exactly one cycle, the first cycle of WAIT_TX.
  - Latency: op-byte rx_done in cycle N, SEND in cycle N+1, o_tx_start high in cycle N+2.
- WAIT_TX: on i_tx_done (any cycle in WAIT_TX), go to WAIT_A. i_tx_done in any other state is ignored.
- Holding of outputs:
  - o_tx_data holds until the next SEND.
  - o_dato_a, o_dato_b and o_operador hold until overwritten by the next frame.
- Overrun:
  - i_rx_done in SEND or WAIT_TX: byte discarded, o_rx_overrun <= 1.
  - o_rx_overrun stays set until reset.
- Timeout, when TIMEOUT_CYCLES > 0:
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - Counter clears on every accepted byte and whenever the state is not WAIT_B or WAIT_OP.
  - In WAIT_B/WAIT_OP, each cycle without i_rx_done increments the counter.
  - At the end of the TIMEOUT_CYCLES-th consecutive idle cycle: state returns to WAIT_A and o_frame_error pulses for one cycle.
  - o_dato_a and o_dato_b keep their partial-frame values.
- Simultaneous i_rx_done and timeout expiry in the same cycle: the byte is accepted and the timeout does not fire.
- WAIT_A has no timeout.
- Sign extension: o_tx_data = {{(NB_UART-NB_DATA){i_resultado[NB_DATA-1]}}, i_resultado}.
- Back-to-back frames: a byte arriving in the same cycle as i_tx_done is an overrun (state is still WAIT_TX). The first A byte is accepted from the cycle after i_tx_done.

Test Plan:
- Defaults. Bytes 0x05, 0x03, 0x20 (ADD), ALU model connected -> o_dato_a=0x05, o_dato_b=0x03, o_operador=0x20. o_tx_start pulses exactly 2 cycles after the third rx_done with o_tx_data=0x08. After i_tx_done the state is WAIT_A.
- Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE.
- Bytes 0x80, 0x02, 0x03 (SRA) -> o_tx_data=0xE0.
- NB_DATA=5, NB_OPERADOR=6. Bytes 0xF0, 0x01, 0xC3 -> o_dato_a=0x10, o_operador=0x03, o_tx_data=0xF8 (sign extension, upper bits dropped).
- TIMEOUT_CYCLES=16:
  - Send 0x11, then idle 16 cycles -> o_frame_error pulses once and state is WAIT_A.
  - Next bytes 0x01, 0x02, 0x25 (OR) -> o_tx_data=0x03.
  - A byte arriving on the 16th idle cycle is accepted and no error is raised.
- Overrun and reset:
  - Byte during WAIT_TX -> o_rx_overrun=1 and the frame is unaffected.
  - Assert i_reset after the B byte -> all outputs 0 and o_rx_overrun=0; the next three bytes form a fresh frame.
